// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path. The immediate
// extender, the ALU and this controller all import the same opcode,
// imm_src and alu_control constants.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format is a pure function of the opcode; anything without
  // its own format (including unsupported opcodes) falls back to I-type.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE: imm_src_of = IMM_S;
      OP_BEQ:   imm_src_of = IMM_B;
      OP_JAL:   imm_src_of = IMM_J;
      default:  imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decoder: maps the controller's coarse aluop plus the
// instruction's funct fields to the 3-bit alu_control code.
// Ports: aluop, funct3, op5, funct7b5 in; alu_control out. Purely combinational.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  aluop_e      aluop,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // sub only for R-type with funct7[5]; addi ignores instr[30]
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for a multicycle RISC-V datapath.
// Ports: clk, rst_n, op/funct3/funct7b5/zero in; mux selects, write enables,
// alu_control, imm_src and an illegal-opcode pulse out.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic [2:0]  alu_control,
  output logic        illegal
);

  state_e state_q, state_d;
  aluop_e aluop;
  logic   pc_update, branch;
  logic   ir_w, reg_w, mem_w, ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    imm_src    = imm_src_of(op);
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    aluop      = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ill        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_w       = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Computes PC+imm into ALUOut ahead of a possible branch.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        aluop     = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // Return address PC+4 (oldPC+4); target already sits in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Enables are gated by rst_n so they drop the instant reset asserts,
  // even though the state register itself parks in FETCH.
  assign ir_write  = rst_n & ir_w;
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign reg_write = rst_n & reg_w;
  assign mem_write = rst_n & mem_w;
  assign illegal   = rst_n & ill;

endmodule
